uart8_transmitter: RTL and testbench
====================================

# uart8_transmitter

8-bit UART transmitter (8N1: one start bit, 8 data bits LSB first, one stop bit). It serializes a parallel byte onto the tx line and is the transmit-side counterpart of the 16x-oversampling receiver. It runs from the same divided-down 16x-baud `clk`, holds every serial bit for exactly 16 ticks, and signals completion with a `done` pulse one baud interval long. Its output must be accepted by the receiver's start-detect and stop-hold checks, including back-to-back frames.

## Interface
- Parameters: none. 16x oversampling and 8N1 framing are fixed.
- `clk` input 1: 16x baud-rate tick clock, identical to the receiver's `clk`.
- `en` input 1: synchronous, active-low reset. Low means held in reset; high means enabled.
- `start` input 1: request to send `in`. Sampled only when a new frame can be accepted.
- `in` input 8: byte to transmit. Captured on the accepting edge; ignored at all other times.
- `out` output 1: tx serial line. Idles high.
- `busy` output 1: a frame is in progress (start, data or stop bit).
- `done` output 1: frame completed. High for exactly 16 ticks.

## Operation
- States: RESET, IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - Internal registers: 4-bit `tick_count`, 3-bit `bit_index`, 8-bit `shift_data`.
  - A separate 5-bit `done_hold_count` runs independently of the state machine.
- Reset, on any edge with `en`=0:
  - Next state is RESET.
  - `out`=1, `busy`=0, `done`=0. All counters and `shift_data` are cleared.
  - This overrides every other action, including mid-frame.
- RESET with `en`=1: go to IDLE and keep the reset output values. `start` is ignored on this edge.
- IDLE:
  - `out`=1, `busy`=0.
  - If `start`=1: capture `in` into `shift_data`, drive `out`<=0, `busy`<=1, `tick_count`<=0, and go to START_BIT.
- START_BIT:
  - `tick_count` increments every edge.
  - At 15 it wraps to 0. Drive `out`<=`shift_data[0]`, set `bit_index`<=0, and go to DATA_BITS.
- DATA_BITS:
  - `tick_count` increments every edge.
  - At 15: if `bit_index`==7, drive `out`<=1 and go to STOP_BIT. Otherwise increment `bit_index` and drive `out`<=`shift_data[bit_index+1]`.
- STOP_BIT:
  - `out` stays 1 while `tick_count` counts 0..15.
  - At 15: `done`<=1 and `done_hold_count`<=1.
  - If `start`=1 on the same edge (back-to-back): capture `in`, drive `out`<=0, go to START_BIT, and keep `busy`=1.
  - Otherwise: `busy`<=0 and go to IDLE.
- Done hold:
  - While `done_hold_count` is nonzero it increments each edge.
  - At 16 it clears to 0 and `done`<=0.
  - This runs independently of state, so `done` stays high during the next frame's start bit.
- `start` in START_BIT, DATA_BITS, or STOP_BIT before tick 15 is ignored. There is no queueing, and `in` may change freely.
- Undefined state encodings go to RESET.

## Timing
- Let T0 be the edge that samples `start`=1 in IDLE.
  - `out`=0 (start bit) for cycles T0+1..T0+16.
  - Data bit k (k=0..7) for cycles T0+17+16k..T0+32+16k.
  - Stop bit (1) for cycles T0+145..T0+160.
- At edge T0+160:
  - `done`=1 for cycles T0+161..T0+176.
  - `busy`=0 from T0+161 unless the frame was chained.
- Latency from `start` to the falling edge of `out`: 1 cycle. Frame length is 160 ticks.
- Back-to-back frames: the next start bit begins at T0+161 with no idle gap. The full 16-tick stop satisfies the receiver's 4-tick minimum high hold.
- Minimum gap between non-chained frames: 1 IDLE cycle. `start` is sampled at the earliest on T0+161.
- Reset mid-frame: `out` returns high on the cycle after the edge that samples `en`=0. The partial frame is abandoned. The receiver is expected to flag the truncated frame as an error; this block does not flag it.

## Test plan
- Single frame: `in`=8'hA5, with `start` high for one cycle after IDLE. Required: `out` shows 0,1,0,1,0,0,1,0,1,1, each held 16 ticks. `busy` is high for 160 cycles. `done` is high for 16 cycles starting at T0+161.
- Back-to-back: send 8'h00 and hold `start`=1 with `in`=8'hFF at the end of the stop bit. Required: the second start bit begins at T0+161. Line sequence is 0, eight 0s, 1, then 0, eight 1s, 1. `busy` never drops. There are two `done` pulses, 160 cycles apart.
- Ignored request: pulse `start` with `in`=8'h3C at T0+50 during an 8'h81 frame. Required: the serialized frame is 8'h81 exactly, and no second frame follows.
- Reset mid-frame: drive `en`=0 at T0+70. Required: next cycle `out`=1, `busy`=0, `done`=0. After `en` rises, a `start` on the first enabled edge is ignored, and one on the second edge is accepted.
- Loopback: connect `out` to the receiver's `in` on the same `clk` and send 8'h3C, 8'hC3, 8'hFF back-to-back. Required: the receiver reports `done` with matching `out` for each byte and `err` is never asserted.

Source files
------------

// File: rtl/uart8_transmitter.sv
// 8N1 UART transmitter on a 16x-baud tick clock: start bit is on the line 1 cycle after start is sampled, and each frame is 160 ticks long.
// There is no queueing: start is only taken in IDLE or on the last stop-bit tick (back-to-back); done is held for 16 ticks.
module uart8_transmitter (
  input  logic       clk,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    IDLE      = 3'd1,
    START_BIT = 3'd2,
    DATA_BITS = 3'd3,
    STOP_BIT  = 3'd4
  } state_t;

  state_t      state_q;
  logic [3:0]  tick_count_q;
  logic [2:0]  bit_index_q;
  logic [7:0]  shift_data_q;
  logic [4:0]  done_hold_count_q;
  logic [2:0]  bit_index_d;

  assign bit_index_d = bit_index_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!en) begin
      state_q           <= RESET;
      out               <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      tick_count_q      <= 4'd0;
      bit_index_q       <= 3'd0;
      shift_data_q      <= 8'd0;
      done_hold_count_q <= 5'd0;
    end else begin
      // The done stretcher runs on its own, so done overlaps a chained start bit.
      if (done_hold_count_q == 5'd16) begin
        done_hold_count_q <= 5'd0;
        done              <= 1'b0;
      end else if (done_hold_count_q != 5'd0) begin
        done_hold_count_q <= done_hold_count_q + 5'd1;
      end

      case (state_q)
        RESET: begin
          state_q <= IDLE;
        end
        IDLE: begin
          out  <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            shift_data_q <= in;
            out          <= 1'b0;
            busy         <= 1'b1;
            tick_count_q <= 4'd0;
            state_q      <= START_BIT;
          end
        end
        START_BIT: begin
          tick_count_q <= tick_count_q + 4'd1;
          if (tick_count_q == 4'd15) begin
            out         <= shift_data_q[0];
            bit_index_q <= 3'd0;
            state_q     <= DATA_BITS;
          end
        end
        DATA_BITS: begin
          tick_count_q <= tick_count_q + 4'd1;
          if (tick_count_q == 4'd15) begin
            if (bit_index_q == 3'd7) begin
              out     <= 1'b1;
              state_q <= STOP_BIT;
            end else begin
              bit_index_q <= bit_index_d;
              out         <= shift_data_q[bit_index_d];
            end
          end
        end
        STOP_BIT: begin
          tick_count_q <= tick_count_q + 4'd1;
          out          <= 1'b1;
          if (tick_count_q == 4'd15) begin
            done              <= 1'b1;
            done_hold_count_q <= 5'd1;
            if (start) begin
              shift_data_q <= in;
              out          <= 1'b0;
              busy         <= 1'b1;
              state_q      <= START_BIT;
            end else begin
              busy    <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= RESET;
          out     <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart8_transmitter.sv
// Bench for uart8_transmitter: a frame-timing reference model predicts out/busy/done every cycle,
// and a mid-bit sampling receiver checks each decoded byte against the bytes the model accepted.
module tb_uart8_transmitter;

  logic       clk;
  logic       en;
  logic       start;
  logic [7:0] in;
  logic       out;
  logic       busy;
  logic       done;

  uart8_transmitter dut (
    .clk   (clk),
    .en    (en),
    .start (start),
    .in    (in),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, e, got, exp);
    end
  endtask

  // Reference model: frames are described by their accept edge and byte.
  int         f_last  = -100000;
  int         done_st = -100000;
  int         ready   = 1 << 30;
  bit         in_rst  = 1'b1;
  logic [7:0] b_last  = 8'd0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    e++;
    if (!en) begin
      in_rst  = 1'b1;
      f_last  = -100000;
      done_st = -100000;
      ready   = 1 << 30;
      exp_q.delete();
    end else if (in_rst) begin
      in_rst = 1'b0;
      ready  = e + 1;
    end else begin
      if (e == f_last + 160) done_st = e;
      if (start && e >= ready) begin
        f_last = e;
        b_last = in;
        ready  = e + 160;
        exp_q.push_back(in);
      end
    end
  end

  function automatic logic exp_out();
    int d;
    int pos;
    d = e - f_last;
    if (d < 0 || d > 159) return 1'b1;
    pos = d / 16;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b_last[pos-1];
  endfunction

  always @(negedge clk) begin
    if (e > 0) begin
      check("out",  {31'd0, out},  {31'd0, exp_out()});
      check("busy", {31'd0, busy}, {31'd0, (e - f_last >= 0 && e - f_last <= 159)});
      check("done", {31'd0, done}, {31'd0, (e - done_st >= 0 && e - done_st <= 15)});
    end
  end

  // Loopback receiver: samples each bit at its 8th tick.
  int         rx_s = -1;
  logic [7:0] rx_byte;
  int         rx_frames = 0;

  always @(negedge clk) begin
    if (e > 0) begin
      if (in_rst) begin
        rx_s = -1;
      end else begin
        if (rx_s < 0) begin
          if (out === 1'b0) rx_s = 0;
        end else begin
          rx_s++;
        end
        if (rx_s == 8) check("rx_start", {31'd0, out}, 32'd0);
        if (rx_s >= 24 && rx_s <= 136 && (rx_s - 24) % 16 == 0)
          rx_byte[(rx_s - 24) / 16] = out;
        if (rx_s == 152) begin
          check("rx_stop", {31'd0, out}, 32'd1);
          if (exp_q.size() == 0) begin
            check("rx_extra_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
          end else begin
            check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
          end
          rx_frames++;
          rx_s = -1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    start = 1'b1;
    in    = b;
    tick(1);
    start = 1'b0;
    in    = 8'($urandom);
  endtask

  int frames_before;

  initial begin
    en    = 1'b0;
    start = 1'b0;
    in    = 8'h00;
    tick(3);
    en = 1'b1;
    tick(4);

    // Single frame.
    send(8'hA5);
    tick(175);

    // Back-to-back 00 then FF on the final stop tick.
    send(8'h00);
    tick(159);
    send(8'hFF);
    tick(180);

    // Request during a frame is dropped.
    frames_before = rx_frames;
    send(8'h81);
    tick(49);
    send(8'h3C);
    tick(250);
    check("ignored_req_frames", rx_frames - frames_before, 1);

    // Reset mid-frame, then first enabled edge ignores start.
    send(8'h5A);
    tick(69);
    en = 1'b0;
    tick(1);
    tick(2);
    en    = 1'b1;
    start = 1'b1;
    in    = 8'h11;
    tick(1);
    in    = 8'h22;
    tick(1);
    start = 1'b0;
    tick(180);

    // Loopback triple, chained.
    frames_before = rx_frames;
    send(8'h3C);
    tick(159);
    send(8'hC3);
    tick(159);
    send(8'hFF);
    tick(180);
    check("loopback_frames", rx_frames - frames_before, 3);

    // start held high: continuous chaining of random bytes.
    start = 1'b1;
    for (int i = 0; i < 600; i++) begin
      in = 8'($urandom);
      tick(1);
    end
    start = 1'b0;
    tick(180);

    // Random requests with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      in    = 8'($urandom);
      en    = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    en    = 1'b1;
    start = 1'b0;
    tick(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
